i2c_reg_bank: RTL

// Register-file stage directly downstream of the SCL-clocked I2C peripheral.
// - Brings byte events from the SCL domain into clk via toggle synchronizers.
// - Decodes the first written byte as a register pointer and stores subsequent written bytes.
// - Presents read data on tx_byte with pointer auto-increment.
// - Exposes control registers to the fabric and samples status inputs for read-back.

---
 rtl/i2c_reg_bank_pkg.sv | 7 +
 rtl/i2c_reg_bank_if.sv | 13 +
 rtl/i2c_reg_bank_toggle_sync.sv | 17 +
 rtl/i2c_reg_bank.sv | 94 +++++++++
 4 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// Shared types and constants for the I2C register-bank stage.
// States, the read-back value for unmapped addresses and the pointer width.
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, PTR, WRITE, READ} i2c_rb_state_t;
  localparam int         PTR_W    = 8;
  localparam logic [7:0] BAD_READ = 8'hFF;
endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-event bus between the SCL-clocked I2C peripheral and the register bank.
// The peripheral is the master and the register bank is the slave.
interface i2c_reg_bank_if;
  logic [7:0] rx_byte;
  logic       rx_tgl;
  logic       tx_tgl;
  logic       start_tgl;
  logic       rw;
  logic [7:0] tx_byte;

  modport master (output rx_byte, rx_tgl, tx_tgl, start_tgl, rw, input tx_byte);
  modport slave  (input rx_byte, rx_tgl, tx_tgl, start_tgl, rw, output tx_byte);
endinterface

// File: rtl/i2c_reg_bank_toggle_sync.sv
// Brings an SCL-domain toggle into clk: a 2-FF synchronizer plus an edge-detect flop.
// pulse_o is high for one clk, with the edge between the 2nd and 3rd stages.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl_i,
  output logic pulse_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tgl_i};
  end

  assign pulse_o = sync_q[1] ^ sync_q[2];
endmodule

// File: rtl/i2c_reg_bank.sv
// Register file behind the I2C peripheral: pointer decode, control registers with
// write strobes, and a registered read mux that drives the next transmitted byte.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int         NUM_RW    = 4,
  parameter int         NUM_RO    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  i2c_reg_bank_if.slave       bus,
  output logic [8*NUM_RW-1:0] ctrl_regs,
  output logic [NUM_RW-1:0]   wr_strobe,
  input  logic [8*NUM_RO-1:0] status_in
);
  logic start_p, rx_p, tx_p;

  toggle_sync u_start_sync (.clk(clk), .rst(rst), .tgl_i(bus.start_tgl), .pulse_o(start_p));
  toggle_sync u_rx_sync    (.clk(clk), .rst(rst), .tgl_i(bus.rx_tgl),    .pulse_o(rx_p));
  toggle_sync u_tx_sync    (.clk(clk), .rst(rst), .tgl_i(bus.tx_tgl),    .pulse_o(tx_p));

  // rw is level-stable around start_tgl, so a plain 2-FF pair lines it up with start_p.
  logic [1:0] rw_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rw_sync_q <= '0;
    else     rw_sync_q <= {rw_sync_q[0], bus.rw};
  end

  i2c_rb_state_t       state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [7:0]          ctrl_q [NUM_RW];
  logic [NUM_RW-1:0]   wr_strobe_q;
  logic [7:0]          tx_byte_q;
  logic [7:0]          tx_byte_d;

  always_comb begin
    tx_byte_d = BAD_READ;
    for (int k = 0; k < NUM_RW; k++) begin
      if (ptr_q == PTR_W'(k)) tx_byte_d = ctrl_q[k];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (ptr_q == PTR_W'(NUM_RW + k)) tx_byte_d = status_in[8*k +: 8];
    end
  end

  // start_p is decoded first so a coincident rx_p/tx_p is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wr_strobe_q <= '0;
      tx_byte_q   <= '0;
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= RESET_VAL;
    end else begin
      wr_strobe_q <= '0;
      tx_byte_q   <= tx_byte_d;
      if (start_p) begin
        state_q <= rw_sync_q[1] ? READ : PTR;
      end else begin
        case (state_q)
          PTR: begin
            if (rx_p) begin
              ptr_q   <= bus.rx_byte;
              state_q <= WRITE;
            end
          end
          WRITE: begin
            if (rx_p) begin
              for (int k = 0; k < NUM_RW; k++) begin
                if (ptr_q == PTR_W'(k)) begin
                  ctrl_q[k]      <= bus.rx_byte;
                  wr_strobe_q[k] <= 1'b1;
                end
              end
              ptr_q <= ptr_q + 1'b1;
            end
          end
          READ: begin
            if (tx_p) ptr_q <= ptr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_ctrl_out
    assign ctrl_regs[8*gi +: 8] = ctrl_q[gi];
  end

  assign wr_strobe   = wr_strobe_q;
  assign bus.tx_byte = tx_byte_q;
endmodule
